// File: rtl/dw_bank_pkg.sv
// Shared constants, state encoding and tuser field packing for the dw_bank_sched
// controller and its keep-mask generator.
package dw_bank_pkg;
   localparam int unsigned KW_MAX       = 11;
   localparam int unsigned SW_MAX       = 4;
   localparam int unsigned I_KW2        = 2;
   localparam int unsigned BITS_KW2     = $clog2(KW_MAX / 2 + 1);
   localparam int unsigned I_SW_1       = I_KW2 + BITS_KW2;
   localparam int unsigned BITS_SW      = $clog2(SW_MAX + 1);
   localparam int unsigned TUSER_WIDTH  = 8;
   localparam int unsigned MEMBERS_DEF  = 24;
   localparam int unsigned BITS_MEMBERS = $clog2(MEMBERS_DEF);

   typedef logic [1:0] state_t;
   localparam state_t IDLE  = 2'd0;
   localparam state_t CALC  = 2'd1;
   localparam state_t RUN   = 2'd2;
   localparam state_t DRAIN = 2'd3;

   function automatic logic [TUSER_WIDTH-1:0] pack_user(input logic [BITS_KW2-1:0] kw2,
                                                        input logic [BITS_SW-1:0]  sw_1);
      logic [TUSER_WIDTH-1:0] u;
      u = '0;
      u[I_KW2 +: BITS_KW2] = kw2;
      u[I_SW_1 +: BITS_SW] = sw_1;
      return u;
   endfunction
endpackage

// File: rtl/dw_keep_mask_gen.sv
// Builds the first-beat and steady keep masks one member per cycle, using a
// wrapping mod-J counter instead of a divider.
module dw_keep_mask_gen
   import dw_bank_pkg::*;
#(
   parameter int unsigned MEMBERS = MEMBERS_DEF,
   parameter int unsigned MW      = BITS_MEMBERS
)(
   input  logic                clk,
   input  logic                rst,
   input  logic                calc_en,
   input  logic [BITS_KW2-1:0] kw2,
   input  logic [BITS_SW-1:0]  sw_1,
   output logic [MEMBERS-1:0]  keep_f,
   output logic [MEMBERS-1:0]  keep_s,
   output logic                done
);
   localparam int unsigned RW = BITS_KW2 + 2;

   logic [MW-1:0]      m_q, m_d;
   logic [RW-1:0]      r_q, r_d;
   logic [MEMBERS-1:0] keep_f_q, keep_f_d, keep_s_q, keep_s_d;
   logic [RW-1:0]      r_last, thr_f, s_sum;

   always_comb begin
      r_last   = RW'({kw2, 1'b0}) + RW'(sw_1);
      thr_f    = RW'({kw2, 1'b0});
      // r >= K-1-S rewritten as r+S >= K-1 so a negative threshold never appears
      s_sum    = r_q + RW'(sw_1) + RW'(1);
      m_d      = m_q;
      r_d      = r_q;
      keep_f_d = keep_f_q;
      keep_s_d = keep_s_q;
      done     = calc_en && (m_q == MW'(MEMBERS - 1));
      if (calc_en) begin
         keep_f_d[m_q] = (r_q >= thr_f);
         keep_s_d[m_q] = (s_sum >= thr_f);
         if (done) begin
            m_d = '0;
            r_d = '0;
         end else begin
            m_d = m_q + MW'(1);
            r_d = (r_q == r_last) ? '0 : r_q + RW'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         m_q      <= '0;
         r_q      <= '0;
         keep_f_q <= '0;
         keep_s_q <= '0;
      end else begin
         m_q      <= m_d;
         r_q      <= r_d;
         keep_f_q <= keep_f_d;
         keep_s_q <= keep_s_d;
      end
   end

   assign keep_f = keep_f_q;
   assign keep_s = keep_s_q;
endmodule

// File: rtl/dw_bank_sched.sv
// Frame sequencer for the axis_dw_shift bank: accepts a config, builds keep masks,
// then streams beats through a one-deep output register stamped with keep/user/last.
module dw_bank_sched
   import dw_bank_pkg::*;
#(
   parameter int unsigned WORD_WIDTH = 8,
   parameter int unsigned UNITS      = 2,
   parameter int unsigned MEMBERS    = MEMBERS_DEF,
   parameter int unsigned BITS_BEATS = 16
)(
   input  logic                             aclk,
   input  logic                             areset,
   input  logic                             cfg_valid,
   output logic                             cfg_ready,
   input  logic [BITS_KW2-1:0]              cfg_kw2,
   input  logic [BITS_SW-1:0]               cfg_sw_1,
   input  logic [BITS_BEATS-1:0]            cfg_beats,
   input  logic                             s_valid,
   output logic                             s_ready,
   input  logic [MEMBERS*UNITS*WORD_WIDTH-1:0] s_data,
   input  logic                             s_last,
   output logic                             m_valid,
   input  logic                             m_ready,
   output logic [MEMBERS*UNITS*WORD_WIDTH-1:0] m_data,
   output logic [MEMBERS-1:0]               m_keep,
   output logic [MEMBERS*TUSER_WIDTH-1:0]   m_user,
   output logic                             m_last,
   output logic                             err_cfg,
   output logic                             err_last
);
   localparam int unsigned DW = MEMBERS * UNITS * WORD_WIDTH;

   state_t                     state_q, state_d;
   logic [BITS_KW2-1:0]        kw2_q, kw2_d;
   logic [BITS_SW-1:0]         sw_1_q, sw_1_d;
   logic [BITS_BEATS-1:0]      beats_q, beats_d, beat_q, beat_d;
   logic                       m_valid_q, m_valid_d, m_last_q, m_last_d;
   logic [DW-1:0]              m_data_q, m_data_d;
   logic [MEMBERS-1:0]         m_keep_q, m_keep_d;
   logic [MEMBERS*TUSER_WIDTH-1:0] m_user_q, m_user_d;
   logic                       err_cfg_q, err_cfg_d, err_last_q, err_last_d;
   logic                       calc_en, calc_done, s_fire, last_beat, cfg_bad;
   logic [MEMBERS-1:0]         keep_f, keep_s;

   dw_keep_mask_gen #(
      .MEMBERS (MEMBERS),
      .MW      ($clog2(MEMBERS))
   ) u_mask (
      .clk     (aclk),
      .rst     (areset),
      .calc_en (calc_en),
      .kw2     (kw2_q),
      .sw_1    (sw_1_q),
      .keep_f  (keep_f),
      .keep_s  (keep_s),
      .done    (calc_done)
   );

   always_comb begin
      state_d    = state_q;
      kw2_d      = kw2_q;
      sw_1_d     = sw_1_q;
      beats_d    = beats_q;
      beat_d     = beat_q;
      m_valid_d  = m_valid_q;
      m_last_d   = m_last_q;
      m_data_d   = m_data_q;
      m_keep_d   = m_keep_q;
      m_user_d   = m_user_q;
      err_cfg_d  = err_cfg_q;
      err_last_d = err_last_q;
      calc_en    = 1'b0;
      cfg_ready  = (state_q == IDLE) && !areset;
      s_ready    = (state_q == RUN) && (!m_valid_q || m_ready);
      s_fire     = s_valid && s_ready;
      last_beat  = (beat_q == beats_q - BITS_BEATS'(1));
      cfg_bad    = (cfg_kw2 > BITS_KW2'(KW_MAX / 2)) || (cfg_sw_1 > BITS_SW'(SW_MAX - 1)) ||
                   (cfg_beats == '0);
      case (state_q)
         IDLE: begin
            if (cfg_valid) begin
               kw2_d   = cfg_kw2;
               sw_1_d  = cfg_sw_1;
               beats_d = cfg_beats;
               beat_d  = '0;
               if (cfg_bad) err_cfg_d = 1'b1;
               else         state_d   = CALC;
            end
         end
         CALC: begin
            calc_en = 1'b1;
            if (calc_done) state_d = RUN;
         end
         RUN: begin
            if (s_fire) begin
               m_valid_d = 1'b1;
               m_data_d  = s_data;
               m_keep_d  = (beat_q == '0) ? keep_f : keep_s;
               m_user_d  = {MEMBERS{pack_user(kw2_q, sw_1_q)}};
               m_last_d  = last_beat;
               beat_d    = beat_q + BITS_BEATS'(1);
               if (s_last != last_beat) err_last_d = 1'b1;
               if (last_beat) state_d = DRAIN;
            end else if (m_ready) begin
               m_valid_d = 1'b0;
            end
         end
         DRAIN: begin
            if (m_ready) begin
               m_valid_d = 1'b0;
               state_d   = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         state_q    <= IDLE;
         kw2_q      <= '0;
         sw_1_q     <= '0;
         beats_q    <= '0;
         beat_q     <= '0;
         m_valid_q  <= 1'b0;
         m_last_q   <= 1'b0;
         m_data_q   <= '0;
         m_keep_q   <= '0;
         m_user_q   <= '0;
         err_cfg_q  <= 1'b0;
         err_last_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         kw2_q      <= kw2_d;
         sw_1_q     <= sw_1_d;
         beats_q    <= beats_d;
         beat_q     <= beat_d;
         m_valid_q  <= m_valid_d;
         m_last_q   <= m_last_d;
         m_data_q   <= m_data_d;
         m_keep_q   <= m_keep_d;
         m_user_q   <= m_user_d;
         err_cfg_q  <= err_cfg_d;
         err_last_q <= err_last_d;
      end
   end

   assign m_valid  = m_valid_q;
   assign m_last   = m_last_q;
   assign m_data   = m_data_q;
   assign m_keep   = m_keep_q;
   assign m_user   = m_user_q;
   assign err_cfg  = err_cfg_q;
   assign err_last = err_last_q;
endmodule

// File: tb/tb_dw_bank_sched.sv
// Randomized self-checking bench for dw_bank_sched with a mask/user/last model
// computed directly from the K, S, J arithmetic.
module tb_dw_bank_sched;
   import dw_bank_pkg::*;

   localparam int unsigned WW  = 8;
   localparam int unsigned UN  = 2;
   localparam int unsigned MEM = 24;
   localparam int unsigned BB  = 16;
   localparam int unsigned DW  = MEM * UN * WW;

   logic                     aclk = 1'b0;
   logic                     areset = 1'b0;
   logic                     cfg_valid = 1'b0;
   logic                     cfg_ready;
   logic [BITS_KW2-1:0]      cfg_kw2 = '0;
   logic [BITS_SW-1:0]       cfg_sw_1 = '0;
   logic [BB-1:0]            cfg_beats = '0;
   logic                     s_valid = 1'b0;
   logic                     s_ready;
   logic [DW-1:0]            s_data = '0;
   logic                     s_last = 1'b0;
   logic                     m_valid;
   logic                     m_ready = 1'b1;
   logic [DW-1:0]            m_data;
   logic [MEM-1:0]           m_keep;
   logic [MEM*TUSER_WIDTH-1:0] m_user;
   logic                     m_last;
   logic                     err_cfg;
   logic                     err_last;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 aclk = ~aclk;

   dw_bank_sched #(
      .WORD_WIDTH (WW),
      .UNITS      (UN),
      .MEMBERS    (MEM),
      .BITS_BEATS (BB)
   ) dut (
      .aclk      (aclk),
      .areset    (areset),
      .cfg_valid (cfg_valid),
      .cfg_ready (cfg_ready),
      .cfg_kw2   (cfg_kw2),
      .cfg_sw_1  (cfg_sw_1),
      .cfg_beats (cfg_beats),
      .s_valid   (s_valid),
      .s_ready   (s_ready),
      .s_data    (s_data),
      .s_last    (s_last),
      .m_valid   (m_valid),
      .m_ready   (m_ready),
      .m_data    (m_data),
      .m_keep    (m_keep),
      .m_user    (m_user),
      .m_last    (m_last),
      .err_cfg   (err_cfg),
      .err_last  (err_last)
   );

   function automatic logic [MEM-1:0] model_keep(input int kw2, input int sw1, input bit first);
      int k, s, j, thr;
      logic [MEM-1:0] v;
      k = 2 * kw2 + 1;
      s = sw1 + 1;
      j = k + s - 1;
      thr = first ? (k - 1) : (k - 1 - s);
      for (int m = 0; m < int'(MEM); m++) v[m] = ((m % j) >= thr);
      return v;
   endfunction

   function automatic logic [MEM*TUSER_WIDTH-1:0] model_user(input int kw2, input int sw1);
      logic [MEM*TUSER_WIDTH-1:0] u;
      int field;
      field = kw2 * (1 << I_KW2) + sw1 * (1 << I_SW_1);
      for (int m = 0; m < int'(MEM); m++) u[m*TUSER_WIDTH +: TUSER_WIDTH] = TUSER_WIDTH'(field);
      return u;
   endfunction

   function automatic logic [DW-1:0] rand_data();
      logic [DW-1:0] d;
      for (int i = 0; i < int'(DW / 32); i++) d[i*32 +: 32] = $urandom;
      return d;
   endfunction

   // Accept a config, time the CALC phase, then stream and score one frame.
   task automatic run_frame(input int kw2, input int sw1, input int beats, input int stall_at,
                            input int stall_len, input int bad_beat, input int sv_pct,
                            input int mr_pct);
      logic [DW-1:0] sent_data [0:63];
      logic [DW-1:0] p_data;
      logic [MEM-1:0] p_keep, e_keep;
      logic [MEM*TUSER_WIDTH-1:0] p_user, e_user;
      logic p_last, e_last, hold;
      int n, sent, got, cyc;
      m_ready = 1'b1;
      @(negedge aclk);
      cfg_valid = 1'b1;
      cfg_kw2   = BITS_KW2'(kw2);
      cfg_sw_1  = BITS_SW'(sw1);
      cfg_beats = BB'(beats);
      #1;
      n_checks++;
      if (cfg_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL cfg_ready_idle got %b exp 1", cfg_ready);
      end
      @(posedge aclk);
      n = 1;
      @(negedge aclk);
      cfg_valid = 1'b0;
      while (s_ready !== 1'b1 && n < 200) begin
         @(posedge aclk);
         n++;
         @(negedge aclk);
      end
      n_checks++;
      if (n != int'(MEM) + 1) begin
         n_fail++;
         $display("FAIL calc_latency got %0d exp %0d", n, MEM + 1);
      end
      e_user = model_user(kw2, sw1);
      sent = 0; got = 0; cyc = 0; hold = 1'b0;
      p_data = '0; p_keep = '0; p_user = '0; p_last = 1'b0;
      while (got < beats && cyc < 2000) begin
         if (cyc >= stall_at && cyc < stall_at + stall_len) m_ready = 1'b0;
         else m_ready = ($urandom_range(99) < 32'(mr_pct));
         if (sent < beats && $urandom_range(99) < 32'(sv_pct)) begin
            s_valid = 1'b1;
            s_data  = rand_data();
            s_last  = ((sent == beats - 1) != (sent == bad_beat));
         end else begin
            s_valid = 1'b0;
            s_last  = 1'b0;
         end
         #1;
         if (hold && m_valid) begin
            n_checks++;
            if (m_data !== p_data || m_keep !== p_keep || m_user !== p_user || m_last !== p_last) begin
               n_fail++;
               $display("FAIL hold_stable got keep %h last %b exp keep %h last %b", m_keep, m_last,
                        p_keep, p_last);
            end
         end
         if (m_valid && !m_ready) begin
            n_checks++;
            if (s_ready !== 1'b0) begin
               n_fail++;
               $display("FAIL s_ready_backpressure got %b exp 0", s_ready);
            end
         end
         if (sent == beats) begin
            n_checks++;
            if (s_ready !== 1'b0) begin
               n_fail++;
               $display("FAIL s_ready_after_last got %b exp 0", s_ready);
            end
         end
         if (m_valid && m_ready) begin
            n_checks++;
            if (got >= sent) begin
               n_fail++;
               $display("FAIL spurious_beat got beat %0d exp only %0d sent", got, sent);
            end else begin
               e_keep = model_keep(kw2, sw1, got == 0);
               e_last = (got == beats - 1);
               if (m_data !== sent_data[got] || m_keep !== e_keep || m_user !== e_user ||
                   m_last !== e_last) begin
                  n_fail++;
                  $display("FAIL beat%0d got keep %h user %h last %b exp keep %h user %h last %b",
                           got, m_keep, m_user, m_last, e_keep, e_user, e_last);
                  if (m_data !== sent_data[got])
                     $display("FAIL beat%0d_data got %h exp %h", got, m_data, sent_data[got]);
               end
            end
            got++;
         end
         if (s_valid && s_ready) begin
            sent_data[sent] = s_data;
            sent++;
         end
         hold   = m_valid && !m_ready;
         p_data = m_data; p_keep = m_keep; p_user = m_user; p_last = m_last;
         @(posedge aclk);
         @(negedge aclk);
         cyc++;
      end
      s_valid = 1'b0;
      s_last  = 1'b0;
      m_ready = 1'b1;
      n_checks++;
      if (got != beats || sent != beats) begin
         n_fail++;
         $display("FAIL frame_count got %0d popped %0d sent exp %0d", got, sent, beats);
      end
      #1;
      n_checks++;
      if (m_valid !== 1'b0 || cfg_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL back_to_idle got m_valid %b cfg_ready %b exp 0 1", m_valid, cfg_ready);
      end
   endtask

   task automatic test_reset();
      #2 areset = 1'b1;
      #1;
      n_checks++;
      if ({m_valid, m_last, m_keep, m_user, m_data, err_cfg, err_last, cfg_ready, s_ready} !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs got valid %b keep %h cfg_ready %b exp all 0", m_valid, m_keep,
                  cfg_ready);
      end
      repeat (2) @(posedge aclk);
      @(negedge aclk);
      areset = 1'b0;
      #1;
      n_checks++;
      if (cfg_ready !== 1'b1 || s_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL post_reset got cfg_ready %b s_ready %b exp 1 0", cfg_ready, s_ready);
      end
   endtask

   task automatic test_full_keep();
      run_frame(0, 0, 2, 9999, 0, -1, 100, 100);
      n_checks++;
      if (err_cfg !== 1'b0 || err_last !== 1'b0) begin
         n_fail++;
         $display("FAIL flags_clean got err_cfg %b err_last %b exp 0 0", err_cfg, err_last);
      end
   endtask

   task automatic test_kw3_random();
      run_frame(1, 0, 3, 9999, 0, -1, 70, 60);
      for (int i = 0; i < 3; i++)
         run_frame(int'($urandom_range(5)), int'($urandom_range(3)),
                   int'($urandom_range(1, 12)), 9999, 0, -1, 75, 65);
   endtask

   task automatic test_stall();
      run_frame(1, 0, 3, 1, 4, -1, 100, 100);
   endtask

   task automatic test_bad_last();
      run_frame(2, 1, 2, 9999, 0, 0, 100, 100);
      n_checks++;
      if (err_last !== 1'b1) begin
         n_fail++;
         $display("FAIL err_last_set got %b exp 1", err_last);
      end
   endtask

   task automatic test_bad_cfg();
      int bad_kw [3];
      int bad_sw [3];
      int bad_bt [3];
      bit seen;
      bad_kw = '{6, 1, 2};
      bad_sw = '{0, 0, 4};
      bad_bt = '{2, 0, 3};
      for (int c = 0; c < 3; c++) begin
         @(negedge aclk);
         cfg_valid = 1'b1;
         cfg_kw2   = BITS_KW2'(bad_kw[c]);
         cfg_sw_1  = BITS_SW'(bad_sw[c]);
         cfg_beats = BB'(bad_bt[c]);
         @(posedge aclk);
         @(negedge aclk);
         cfg_valid = 1'b0;
         #1;
         n_checks++;
         if (err_cfg !== 1'b1 || cfg_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL bad_cfg%0d got err_cfg %b cfg_ready %b exp 1 1", c, err_cfg, cfg_ready);
         end
         seen = 1'b0;
         repeat (30) begin
            @(negedge aclk);
            if (s_ready !== 1'b0) seen = 1'b1;
         end
         n_checks++;
         if (seen !== 1'b0) begin
            n_fail++;
            $display("FAIL bad_cfg%0d_s_ready got 1 exp 0", c);
         end
      end
   endtask

   task automatic test_reset_mid_run();
      int n;
      @(negedge aclk);
      cfg_valid = 1'b1;
      cfg_kw2   = BITS_KW2'(1);
      cfg_sw_1  = BITS_SW'(1);
      cfg_beats = BB'(4);
      @(posedge aclk);
      @(negedge aclk);
      cfg_valid = 1'b0;
      n = 0;
      while (s_ready !== 1'b1 && n < 100) begin
         @(negedge aclk);
         n++;
      end
      m_ready = 1'b0;
      s_valid = 1'b1;
      s_data  = rand_data();
      @(posedge aclk);
      @(negedge aclk);
      s_valid = 1'b0;
      #1;
      n_checks++;
      if (m_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL mid_run_loaded got m_valid %b exp 1", m_valid);
      end
      areset = 1'b1;
      #1;
      n_checks++;
      if ({m_valid, m_last, m_keep, m_user, m_data, err_cfg, err_last, cfg_ready, s_ready} !== '0) begin
         n_fail++;
         $display("FAIL mid_run_reset got valid %b keep %h err %b%b exp all 0", m_valid, m_keep,
                  err_cfg, err_last);
      end
      @(negedge aclk);
      areset  = 1'b0;
      m_ready = 1'b1;
      run_frame(1, 1, 4, 9999, 0, -1, 80, 70);
   endtask

   initial begin
      test_reset();
      test_full_keep();
      test_kw3_random();
      test_stall();
      test_bad_last();
      test_bad_cfg();
      test_reset_mid_run();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/dw_bank_sched.md
Name: dw_bank_sched

Overview:
- Sequencing controller that sits in front of the axis_dw_shift width-converter bank.
- Accepts one per-frame config (kernel half-width, stride-1, beat count) on a small valid/ready port.
- Precomputes the per-member keep masks sequentially, then streams MEMBERS×UNITS beats from the upstream engine to the bank.
- Stamps m_keep, m_user (KW2/SW_1 fields) and m_last on every beat, through a one-deep output register.

Parameters:
- WORD_WIDTH, 8, bits per word
- UNITS, 2, words per member
- MEMBERS, 24, members per beat
- KW_MAX, 11, max kernel width (odd)
- SW_MAX, 4, max stride
- I_KW2, 2, LSB of KW2 field in tuser
- BITS_KW2, $clog2(KW_MAX/2+1), KW2 field width
- I_SW_1, I_KW2+BITS_KW2, LSB of SW_1 field
- BITS_SW, $clog2(SW_MAX+1), SW_1 field width
- TUSER_WIDTH, `TUSER_WIDTH_LRELU_IN, tuser width per member
- BITS_BEATS, 16, beat counter width

Ports:
- aclk in 1 clock
- areset in 1 async active-high reset
- cfg_valid in 1 config valid
- cfg_ready out 1 config accepted (IDLE only)
- cfg_kw2 in BITS_KW2 K/2
- cfg_sw_1 in BITS_SW S-1
- cfg_beats in BITS_BEATS beats in frame
- s_valid in 1 upstream valid
- s_ready out 1 upstream ready
- s_data in MEMBERS*UNITS*WORD_WIDTH upstream data
- s_last in 1 upstream last (checked only)
- m_valid out 1 to bank
- m_ready in 1 from bank
- m_data out MEMBERS*UNITS*WORD_WIDTH data
- m_keep out MEMBERS keep mask
- m_user out MEMBERS*TUSER_WIDTH per-member user
- m_last out 1 frame last
- err_cfg out 1 sticky: config rejected
- err_last out 1 sticky: s_last mismatch

Behaviour:
- Reset (async, areset=1): state=IDLE; m_valid, m_last, m_keep, m_user, m_data, err_cfg, err_last = 0; cfg_ready=0 during reset.
- Derived values: K=2*kw2+1, S=sw_1+1, J=K+S-1.
- Mask rules:
  - first-beat mask keep_f[m] = (m mod J) >= K-1
  - steady mask keep_s[m] = (m mod J) >= K-1-S; if K-1-S<0, all ones.
- IDLE:
  - cfg_ready=1, s_ready=0.
  - On cfg_valid, latch fields.
  - If kw2 > KW_MAX/2, or sw_1 > SW_MAX-1, or cfg_beats==0: set err_cfg, stay IDLE.
  - Otherwise go to CALC.
- CALC:
  - Exactly MEMBERS cycles; member index m 0→MEMBERS-1.
  - mod-J counter r increments and wraps to 0 at J-1; no divider.
  - Each cycle writes keep_f[m], keep_s[m] from r.
  - Exit to RUN on m==MEMBERS-1. s_ready=0 throughout.
- RUN:
  - s_ready = !m_valid || m_ready.
  - On s_valid&&s_ready, load the output register:
    - data
    - keep (keep_f if beat index 0, else keep_s)
    - m_user with KW2 at [I_KW2+:BITS_KW2], SW_1 at [I_SW_1+:BITS_SW], other bits 0, replicated across members
    - m_last = (beat == cfg_beats-1).
  - On an accepted beat, if s_last != computed m_last, set err_last; the data still passes.
  - When the accepted beat is the last one, s_ready drops and the block goes to DRAIN.
- DRAIN: hold m_valid until m_ready, then go to IDLE.
- If m_valid&&!m_ready, all m_* outputs stay stable.
- Simultaneous input load and output pop in RUN: the register is reloaded in the same cycle with no bubble.
- Latency:
  - cfg accept → first s_ready: MEMBERS+1 cycles.
  - s beat → m_valid: 1 cycle.
  - Throughput: 1 beat/cycle under continuous m_ready.
- Sticky error flags are cleared only by reset.

Decomposition:
- Package dw_bank_pkg holds:
  - the state enum (IDLE, CALC, RUN, DRAIN)
  - derived width constants BITS_KW2, BITS_SW, I_SW_1, BITS_MEMBERS
  - a function that packs the tuser fields
- Sub-module dw_keep_mask_gen holds the CALC-phase mod-J counter and the two mask registers.
- The FSM and output register stay in the top module.

Test Plan:
- kw2=0, sw_1=0, beats=2 → err_cfg=0; s_ready rises 25 cycles after accept; both beats m_keep=0xFFFFFF; m_last only on beat 1; user fields KW2=0, SW_1=0.
- kw2=1, sw_1=0, beats=3 → beat0 m_keep=0x924924; beats1-2 m_keep=0xDB6DB6; m_user KW2=1 in every member.
- Same config as above, m_ready low 4 cycles mid-frame → s_ready low, m_data/m_keep held stable, no beat lost or duplicated; back to IDLE after the last pop.
- kw2=6 (>5) or beats=0 → err_cfg=1, cfg_ready stays 1, s_ready never asserts.
- beats=2 with s_last=1 on beat 0 → err_last=1; m_last follows the counter (beat 1 only).
- areset pulsed during RUN → all outputs 0 immediately; a new cfg is then accepted and the frame runs normally.
